// File: rtl/config_pkg.sv
// Shared configuration for the vector loader / ternary matmul datapath:
// sizes, element and DDR types, and the word-unpacking geometry.
package config_pkg;

    localparam int D                   = 64;
    localparam int FixedPointPrecision = 16;
    localparam int DdrDataWidth        = 512;
    localparam int DdrAddrWidth        = 32;

    typedef logic [FixedPointPrecision-1:0] fixed_point_t;
    typedef logic [DdrAddrWidth-1:0]        ddr_address_t;
    typedef logic [DdrDataWidth-1:0]        ddr_data_t;
    typedef logic [$clog2(D)-1:0]           DI_t;

    // Number of vector elements carried by one DDR word, and the number of
    // DDR words that make up a full vector.
    localparam int ElemsPerWord = DdrDataWidth / FixedPointPrecision;
    localparam int NumDdrReads  = D / ElemsPerWord;

    // A DDR word viewed as an array of elements; element 0 sits in the LSBs.
    typedef logic [ElemsPerWord-1:0][FixedPointPrecision-1:0] ddr_word_elems_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_HANDOFF = 2'd2
    } loader_state_t;

endpackage

// File: rtl/vector_loader.sv
// Fetches the input vector from DDR word by word, unpacks each word into the
// vector memory one element per cycle, then offers the matrix address to the
// matmul over a valid/ready handshake.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | waiting for a command; in_ready_o high
// ST_LOADING | owns DDR read port and vector-memory write port; fetch + unpack
// ST_HANDOFF | vector complete; out_valid_o high until out_ready_i
module vector_loader
    import config_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    output logic         in_ready_o,
    input  logic         in_valid_i,
    input  ddr_address_t vector_address_i,
    input  ddr_address_t matrix_address_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output ddr_address_t matrix_address_o,
    output DI_t          vector_addr_o,
    output logic         vector_w_en_o,
    output fixed_point_t vector_w_data_o,
    output ddr_address_t ddr_address_o,
    output logic         ddr_r_en_o,
    input  ddr_data_t    ddr_r_data_i,
    input  logic         ddr_r_valid_i,
    input  logic         ddr_waitrequest_n_i
);

    if (D % ElemsPerWord != 0) begin : g_bad_vector_length
        $error("vector_loader: D must be a multiple of ElemsPerWord");
    end

    localparam int CntW = $clog2(NumDdrReads + 1);
    localparam int IdxW = (ElemsPerWord > 1) ? $clog2(ElemsPerWord) : 1;

    localparam logic [CntW-1:0] NumReads = CntW'(NumDdrReads);
    localparam logic [CntW-1:0] LastWord = CntW'(NumDdrReads - 1);
    localparam logic [IdxW-1:0] LastElem = IdxW'(ElemsPerWord - 1);

    loader_state_t   state_q;
    ddr_address_t    vector_addr_q;
    ddr_address_t    matrix_addr_q;
    logic [CntW-1:0] req_cnt_q;      // DDR reads issued
    logic [CntW-1:0] word_idx_q;     // DDR words received / being unpacked
    logic [IdxW-1:0] elem_idx_q;     // element within the buffered word
    logic            outstanding_q;
    logic            buf_valid_q;
    ddr_word_elems_t buf_q;

    logic last_elem;
    logic wr_fire;
    logic rd_issue;
    logic rsp_accept;

    // Read issue and unpack strobes; a new read may overlap the final write of
    // the previous word so the buffer refills without a bubble.
    always_comb begin
        last_elem  = (elem_idx_q == LastElem);
        wr_fire    = (state_q == ST_LOADING) && buf_valid_q;
        rd_issue   = (state_q == ST_LOADING) && (req_cnt_q < NumReads) &&
                     !outstanding_q && ddr_waitrequest_n_i &&
                     (!buf_valid_q || last_elem);
        rsp_accept = ddr_r_valid_i && outstanding_q;
    end

    assign in_ready_o       = (state_q == ST_IDLE);
    assign out_valid_o      = (state_q == ST_HANDOFF);
    assign matrix_address_o = matrix_addr_q;
    assign ddr_r_en_o       = rd_issue;
    assign ddr_address_o    = vector_addr_q + ddr_address_t'(req_cnt_q);
    assign vector_w_en_o    = wr_fire;
    assign vector_addr_o    = DI_t'(word_idx_q) * DI_t'(ElemsPerWord) + DI_t'(elem_idx_q);
    assign vector_w_data_o  = buf_q[elem_idx_q];

    // Word buffer captures a DDR response only when a read is outstanding.
    always_ff @(posedge clk_i) begin
        if (rsp_accept) begin
            buf_q <= ddr_r_data_i;
        end
    end

    // Control FSM, request/response counters and unpack index.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            vector_addr_q <= '0;
            matrix_addr_q <= '0;
            req_cnt_q     <= '0;
            word_idx_q    <= '0;
            elem_idx_q    <= '0;
            outstanding_q <= 1'b0;
            buf_valid_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        vector_addr_q <= vector_address_i;
                        matrix_addr_q <= matrix_address_i;
                        req_cnt_q     <= '0;
                        word_idx_q    <= '0;
                        elem_idx_q    <= '0;
                        outstanding_q <= 1'b0;
                        buf_valid_q   <= 1'b0;
                        state_q       <= ST_LOADING;
                    end
                end
                ST_LOADING: begin
                    if (wr_fire) begin
                        if (last_elem) begin
                            elem_idx_q  <= '0;
                            buf_valid_q <= 1'b0;
                            word_idx_q  <= word_idx_q + CntW'(1);
                            if (word_idx_q == LastWord) begin
                                state_q <= ST_HANDOFF;
                            end
                        end else begin
                            elem_idx_q <= elem_idx_q + IdxW'(1);
                        end
                    end
                    if (rd_issue) begin
                        outstanding_q <= 1'b1;
                        req_cnt_q     <= req_cnt_q + CntW'(1);
                    end
                    // A response can only follow a drained buffer, so it takes
                    // precedence over the clear from the final write.
                    if (rsp_accept) begin
                        outstanding_q <= 1'b0;
                        buf_valid_q   <= 1'b1;
                    end
                end
                ST_HANDOFF: begin
                    if (out_ready_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_loader.sv
// Directed bench for vector_loader: a DDR model with configurable latency and
// backpressure, a scoreboard of expected reads and element writes, and a
// negedge monitor that compares every DUT strobe against the scoreboard.
module tb_vector_loader;
    import config_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         in_ready_o;
    logic         in_valid_i = 1'b0;
    ddr_address_t vector_address_i = '0;
    ddr_address_t matrix_address_i = '0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b0;
    ddr_address_t matrix_address_o;
    DI_t          vector_addr_o;
    logic         vector_w_en_o;
    fixed_point_t vector_w_data_o;
    ddr_address_t ddr_address_o;
    logic         ddr_r_en_o;
    ddr_data_t    ddr_r_data_i = '0;
    logic         ddr_r_valid_i = 1'b0;
    logic         ddr_waitrequest_n_i = 1'b1;

    vector_loader dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .in_ready_o          (in_ready_o),
        .in_valid_i          (in_valid_i),
        .vector_address_i    (vector_address_i),
        .matrix_address_i    (matrix_address_i),
        .out_valid_o         (out_valid_o),
        .out_ready_i         (out_ready_i),
        .matrix_address_o    (matrix_address_o),
        .vector_addr_o       (vector_addr_o),
        .vector_w_en_o       (vector_w_en_o),
        .vector_w_data_o     (vector_w_data_o),
        .ddr_address_o       (ddr_address_o),
        .ddr_r_en_o          (ddr_r_en_o),
        .ddr_r_data_i        (ddr_r_data_i),
        .ddr_r_valid_i       (ddr_r_valid_i),
        .ddr_waitrequest_n_i (ddr_waitrequest_n_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int        due;
        ddr_data_t data;
    } resp_t;

    typedef struct {
        DI_t          addr;
        fixed_point_t data;
    } wr_t;

    resp_t        resp_q[$];
    wr_t          exp_wr_q[$];
    ddr_address_t exp_rd_q[$];
    ddr_data_t    mem[ddr_address_t];

    int           total = 0;
    int           bad = 0;
    int           lat = 3;
    bit           stray_req = 0;
    ddr_address_t exp_matrix = '0;
    int           wr_cnt = 0;
    int           rd_cnt = 0;
    int           first_rd_cyc = -1;
    int           accept_cyc = 0;
    int           valid_cyc = 0;
    bit           valid_seen = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // DDR model: returns the word for each request `lat` cycles later and can
    // inject one stray response pulse on request.
    always begin
        @(posedge clk_i);
        #1;
        ddr_r_valid_i = 1'b0;
        if (resp_q.size() != 0 && resp_q[0].due <= cyc) begin
            ddr_r_valid_i = 1'b1;
            ddr_r_data_i  = resp_q[0].data;
            resp_q.delete(0);
        end else if (stray_req) begin
            ddr_r_valid_i = 1'b1;
            ddr_r_data_i  = {16{$urandom}};
            stray_req     = 0;
        end
    end

    // Monitor: every read and write strobe is checked against the scoreboard.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (in_valid_i && in_ready_o) begin
                accept_cyc   = cyc;
                wr_cnt       = 0;
                rd_cnt       = 0;
                first_rd_cyc = -1;
                valid_seen   = 0;
            end
            if (ddr_r_en_o) begin
                check("rd_waitreq", {63'd0, ddr_waitrequest_n_i}, 64'd1);
                if (exp_rd_q.size() == 0) begin
                    check("rd_unexpected", {63'd0, ddr_r_en_o}, 64'd0);
                end else begin
                    check("rd_addr", {32'd0, ddr_address_o}, {32'd0, exp_rd_q[0]});
                    exp_rd_q.delete(0);
                end
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                rd_cnt++;
                resp_q.push_back('{cyc + lat, mem.exists(ddr_address_o) ? mem[ddr_address_o] : '0});
            end
            if (vector_w_en_o) begin
                if (exp_wr_q.size() == 0) begin
                    check("wr_unexpected", {63'd0, vector_w_en_o}, 64'd0);
                end else begin
                    check("wr_addr", {58'd0, vector_addr_o}, {58'd0, exp_wr_q[0].addr});
                    check("wr_data", {48'd0, vector_w_data_o}, {48'd0, exp_wr_q[0].data});
                    exp_wr_q.delete(0);
                end
                wr_cnt++;
            end
            if (out_valid_o) begin
                check("hand_matrix", {32'd0, matrix_address_o}, {32'd0, exp_matrix});
                check("hand_quiet", {62'd0, ddr_r_en_o, vector_w_en_o}, 64'd0);
                check("hand_inready", {63'd0, in_ready_o}, 64'd0);
                if (!valid_seen) begin
                    valid_seen = 1;
                    valid_cyc  = cyc;
                end
            end
        end
    end

    task automatic fill_random(input ddr_address_t base);
        for (int k = 0; k < NumDdrReads; k++) mem[base + ddr_address_t'(k)] = {16{$urandom}};
    endtask

    task automatic send_cmd(input ddr_address_t va, input ddr_address_t ma);
        int n = 0;
        ddr_data_t w;
        while (!in_ready_o && n < 200) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        check("cmd_ready", {63'd0, in_ready_o}, 64'd1);
        exp_matrix = ma;
        for (int k = 0; k < NumDdrReads; k++) begin
            exp_rd_q.push_back(va + ddr_address_t'(k));
            w = mem[va + ddr_address_t'(k)];
            for (int j = 0; j < ElemsPerWord; j++)
                exp_wr_q.push_back('{DI_t'(k * ElemsPerWord + j), w[j*FixedPointPrecision +: FixedPointPrecision]});
        end
        @(posedge clk_i);
        #1;
        in_valid_i       = 1'b1;
        vector_address_i = va;
        matrix_address_i = ma;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid_o && n < 1000) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        check("valid_timeout", {63'd0, out_valid_o}, 64'd1);
        check("wr_count", wr_cnt, D);
        check("rd_count", rd_cnt, NumDdrReads);
        check("sb_empty", exp_wr_q.size() + exp_rd_q.size(), 0);
    endtask

    task automatic wait_writes(input int target);
        int n = 0;
        while (wr_cnt < target && n < 500) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        check("wr_progress_timeout", {63'd0, wr_cnt >= target}, 64'd1);
    endtask

    task automatic handshake(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            #1;
            check("hold_valid", {63'd0, out_valid_o}, 64'd1);
        end
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b0;
        @(negedge clk_i);
        check("post_hs_ready", {63'd0, in_ready_o}, 64'd1);
        check("post_hs_valid", {63'd0, out_valid_o}, 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {63'd0, in_ready_o}, 64'd1);
        check({tag, "_out_valid"}, {63'd0, out_valid_o}, 64'd0);
        check({tag, "_r_en"}, {63'd0, ddr_r_en_o}, 64'd0);
        check({tag, "_w_en"}, {63'd0, vector_w_en_o}, 64'd0);
    endtask

    initial begin
        ddr_data_t w;
        int        rise_cyc;
        logic [15:0] ext_pat [3];
        ext_pat[0] = 16'h8000;
        ext_pat[1] = 16'h7FFF;
        ext_pat[2] = 16'hFFFF;

        // Reset
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("reset");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // 1: basic load, element i holds i+1, latency 3
        for (int k = 0; k < NumDdrReads; k++) begin
            w = '0;
            for (int j = 0; j < ElemsPerWord; j++)
                w[j*FixedPointPrecision +: FixedPointPrecision] = fixed_point_t'(k * ElemsPerWord + j + 1);
            mem[ddr_address_t'(32'h100 + k)] = w;
        end
        lat = 3;
        send_cmd(32'h100, 32'h200);
        wait_valid();
        check("basic_latency", valid_cyc - accept_cyc, 72);
        handshake(0);

        // 2: DDR backpressure at the first request
        fill_random(32'h300);
        lat = 5;
        ddr_waitrequest_n_i = 1'b0;
        send_cmd(32'h300, 32'h1234);
        repeat (9) begin
            @(posedge clk_i);
            #1;
        end
        ddr_waitrequest_n_i = 1'b1;
        rise_cyc = cyc;
        wait_valid();
        check("bp_first_rd", first_rd_cyc, rise_cyc);
        check("bp_latency", valid_cyc - rise_cyc, NumDdrReads * (lat + ElemsPerWord) + 1);
        handshake(0);

        // 3: handoff held for 20 cycles, stray response during the hold
        fill_random(32'h400);
        lat = 1;
        send_cmd(32'h400, 32'h5A5A);
        wait_valid();
        check("lat1_latency", valid_cyc - accept_cyc, 1 + NumDdrReads * (lat + ElemsPerWord) + 1);
        stray_req = 1;
        handshake(20);

        // 4: extreme values, plus a stray response mid-unpack
        for (int k = 0; k < NumDdrReads; k++) begin
            w = '0;
            for (int j = 0; j < ElemsPerWord; j++)
                w[j*FixedPointPrecision +: FixedPointPrecision] = ext_pat[(k * ElemsPerWord + j) % 3];
            mem[ddr_address_t'(32'h500 + k)] = w;
        end
        lat = 2;
        send_cmd(32'h500, 32'h600);
        wait_writes(10);
        stray_req = 1;
        wait_valid();
        handshake(0);

        // 5: reset at write 40, stray response afterwards, then a clean load
        fill_random(32'h700);
        lat = 3;
        send_cmd(32'h700, 32'h777);
        wait_writes(40);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        exp_wr_q.delete();
        exp_rd_q.delete();
        resp_q.delete();
        @(negedge clk_i);
        check_reset_outputs("midrst");
        @(posedge clk_i);
        #1;
        rst_i     = 1'b0;
        stray_req = 1;
        repeat (6) @(negedge clk_i);
        check_reset_outputs("post_rst");
        fill_random(32'h800);
        send_cmd(32'h800, 32'h900);
        wait_valid();
        check("rst_latency", valid_cyc - accept_cyc, 1 + NumDdrReads * (lat + ElemsPerWord) + 1);
        handshake(0);

        // 6: spurious valid while idle must not produce writes
        stray_req = 1;
        repeat (5) @(negedge clk_i);
        check("idle_quiet_w_en", {63'd0, vector_w_en_o}, 64'd0);
        fill_random(32'hA00);
        send_cmd(32'hA00, 32'hB00);
        wait_valid();
        handshake(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
